// File: rtl/lcd_pkg.sv
// Shared LCD register definitions: FSM states and the field layout of the store word at 0x7030.
// The LSU imports this package to decode the same register.
package lcd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    EXEC
  } lcd_state_e;

  localparam int LCD_ON_BIT   = 31;
  localparam int LCD_RS_BIT   = 9;
  localparam int LCD_DATA_MSB = 7;
  localparam int LCD_DATA_LSB = 0;

  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME  = 8'h02;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Clear and home are the only instructions with the long execution time.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    return !rs && ((data == CMD_CLEAR) || (data == CMD_HOME));
  endfunction

endpackage

// File: rtl/lcd_ctrl.sv
// Write-only HD44780-style LCD bus controller: sequences setup, enable pulse, hold and
// execution wait for each accepted register store, using one shared down-counter.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int T_SETUP = 2,
  parameter int T_PW    = 23,
  parameter int T_HOLD  = 2,
  parameter int T_EXEC  = 2000,
  parameter int T_CLR   = 82000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lcd_wr_en,
  input  logic [31:0] lcd_wdata,
  output logic        lcd_on,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic [7:0]  lcd_data,
  output logic        lcd_busy,
  output logic        lcd_drop
);

  localparam int T_MAX = max_int(max_int(max_int(T_SETUP, T_PW), max_int(T_HOLD, T_EXEC)), T_CLR);
  localparam int CNT_W = $clog2(T_MAX) + 1;

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t LD_SETUP = cnt_t'(T_SETUP - 1);
  localparam cnt_t LD_PW    = cnt_t'(T_PW - 1);
  localparam cnt_t LD_HOLD  = cnt_t'(T_HOLD - 1);
  localparam cnt_t LD_EXEC  = cnt_t'(T_EXEC - 1);
  localparam cnt_t LD_CLR   = cnt_t'(T_CLR - 1);

  lcd_state_e  state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic        on_q, on_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;
  logic        en_q, en_d;
  logic        busy_q, busy_d;
  logic        drop_q, drop_d;

  logic        cnt_zero;
  logic        can_accept;
  logic        unused_wdata;

  assign unused_wdata = ^{lcd_wdata[LCD_ON_BIT-1:LCD_RS_BIT+1],
                          lcd_wdata[LCD_RS_BIT-1:LCD_DATA_MSB+1]};

  assign cnt_zero = (cnt_q == '0);
  // The final EXEC edge doubles as an idle edge so back-to-back writes need no gap.
  assign can_accept = (state_q == IDLE) || ((state_q == EXEC) && cnt_zero);

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    on_d    = on_q;
    rs_d    = rs_q;
    data_d  = data_q;
    drop_d  = drop_q;

    if (lcd_wr_en && can_accept) begin
      on_d    = lcd_wdata[LCD_ON_BIT];
      rs_d    = lcd_wdata[LCD_RS_BIT];
      data_d  = lcd_wdata[LCD_DATA_MSB:LCD_DATA_LSB];
      drop_d  = 1'b0;
      cnt_d   = LD_SETUP;
      state_d = SETUP;
    end else begin
      if (lcd_wr_en) drop_d = 1'b1;
      case (state_q)
        SETUP: begin
          if (cnt_zero) begin
            state_d = PULSE;
            cnt_d   = LD_PW;
          end else begin
            cnt_d = cnt_q - cnt_t'(1);
          end
        end
        PULSE: begin
          if (cnt_zero) begin
            state_d = HOLD;
            cnt_d   = LD_HOLD;
          end else begin
            cnt_d = cnt_q - cnt_t'(1);
          end
        end
        HOLD: begin
          if (cnt_zero) begin
            state_d = EXEC;
            cnt_d   = is_slow_cmd(rs_q, data_q) ? LD_CLR : LD_EXEC;
          end else begin
            cnt_d = cnt_q - cnt_t'(1);
          end
        end
        EXEC: begin
          if (cnt_zero) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - cnt_t'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Strobe and busy are registered decodes of the next state.
    en_d   = (state_d == PULSE);
    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      on_q    <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      on_q    <= on_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

  assign lcd_on   = on_q;
  assign lcd_rs   = rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_en   = en_q;
  assign lcd_data = data_q;
  assign lcd_busy = busy_q;
  assign lcd_drop = drop_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: table of writes with a scoreboard of expected strobes and
// busy widths, plus hand sequences for dropped writes, back-to-back writes and mid-transfer reset.
module tb_lcd_ctrl;

  localparam int T_SETUP = 2;
  localparam int T_PW    = 4;
  localparam int T_HOLD  = 2;
  localparam int T_EXEC  = 10;
  localparam int T_CLR   = 30;
  localparam int HALF    = 5;
  localparam int PERIOD  = 2 * HALF;
  localparam int N_VEC   = 9;

  typedef struct {
    logic [31:0] wdata;
    bit          chain;
    int          busy_len;
    logic        on;
    logic        rs;
    logic [7:0]  data;
  } vec_t;

  typedef struct {
    time         acc_t;
    logic        on;
    logic        rs;
    logic [7:0]  data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        lcd_wr_en;
  logic [31:0] lcd_wdata;
  logic        lcd_on;
  logic        lcd_rs;
  logic        lcd_rw;
  logic        lcd_en;
  logic [7:0]  lcd_data;
  logic        lcd_busy;
  logic        lcd_drop;

  exp_t sb[$];
  int   exp_busy[$];
  int   checks = 0;
  int   errors = 0;

  lcd_ctrl #(
    .T_SETUP(T_SETUP),
    .T_PW   (T_PW),
    .T_HOLD (T_HOLD),
    .T_EXEC (T_EXEC),
    .T_CLR  (T_CLR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .lcd_wr_en(lcd_wr_en),
    .lcd_wdata(lcd_wdata),
    .lcd_on   (lcd_on),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_en   (lcd_en),
    .lcd_data (lcd_data),
    .lcd_busy (lcd_busy),
    .lcd_drop (lcd_drop)
  );

  always #HALF clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic report_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at t=%0t", name, $time);
  endtask

  function automatic vec_t mk(input logic [31:0] w, input bit chain, input int len,
                              input logic on, input logic rs, input logic [7:0] data);
    vec_t v;
    v.wdata    = w;
    v.chain    = chain;
    v.busy_len = len;
    v.on       = on;
    v.rs       = rs;
    v.data     = data;
    return v;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_on"},   32'(lcd_on),   32'h0);
    check({tag, "_rs"},   32'(lcd_rs),   32'h0);
    check({tag, "_rw"},   32'(lcd_rw),   32'h0);
    check({tag, "_en"},   32'(lcd_en),   32'h0);
    check({tag, "_data"}, 32'(lcd_data), 32'h0);
    check({tag, "_busy"}, 32'(lcd_busy), 32'h0);
    check({tag, "_drop"}, 32'(lcd_drop), 32'h0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (lcd_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (lcd_busy) report_fail("busy_timeout");
  endtask

  task automatic wait_en();
    int n = 0;
    while (!lcd_en && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!lcd_en) report_fail("en_timeout");
  endtask

  // Drives one accepted write; entered just after a negedge, returns one negedge after accept.
  task automatic do_write(input vec_t v);
    exp_t e;
    lcd_wr_en = 1'b1;
    lcd_wdata = v.wdata;
    @(posedge clk);
    e.acc_t = $time;
    e.on    = v.on;
    e.rs    = v.rs;
    e.data  = v.data;
    sb.push_back(e);
    if (v.chain && exp_busy.size() > 0) exp_busy[exp_busy.size()-1] += v.busy_len;
    else exp_busy.push_back(v.busy_len);
    @(negedge clk);
    lcd_wr_en = 1'b0;
    check("busy_after_accept", 32'(lcd_busy), 32'h1);
    check("drop_after_accept", 32'(lcd_drop), 32'h0);
  endtask

  // Monitor: compares each completed enable strobe and each busy run against the scoreboard.
  initial begin
    exp_t e;
    time  en_rise_t   = 0;
    time  busy_rise_t = 0;
    logic en_prev     = 1'b0;
    logic busy_prev   = 1'b0;
    int   exp_len;
    forever begin
      @(negedge clk);
      if (rst) begin
        en_prev   = 1'b0;
        busy_prev = 1'b0;
      end else begin
        if (lcd_en && !en_prev) en_rise_t = $time - HALF;
        if (!lcd_en && en_prev) begin
          if (sb.size() == 0) begin
            report_fail("strobe_unexpected");
          end else begin
            e = sb.pop_front();
            check("en_start",   32'((en_rise_t - e.acc_t) / PERIOD), 32'd2);
            check("en_width",   32'(($time - HALF - en_rise_t) / PERIOD), 32'd4);
            check("strobe_data", 32'(lcd_data), 32'(e.data));
            check("strobe_rs",   32'(lcd_rs),   32'(e.rs));
            check("strobe_on",   32'(lcd_on),   32'(e.on));
            check("strobe_rw",   32'(lcd_rw),   32'h0);
          end
        end
        if (lcd_busy && !busy_prev) busy_rise_t = $time;
        if (!lcd_busy && busy_prev) begin
          if (exp_busy.size() == 0) begin
            report_fail("busy_unexpected");
          end else begin
            exp_len = exp_busy.pop_front();
            check("busy_width", 32'(($time - busy_rise_t) / PERIOD), 32'(exp_len));
          end
        end
        en_prev   = lcd_en;
        busy_prev = lcd_busy;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete at t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[N_VEC];
    int   prev_len = 0;

    vecs[0] = mk(32'h8000_0241, 1'b0, 18, 1'b1, 1'b1, 8'h41);
    vecs[1] = mk(32'h8000_0001, 1'b0, 38, 1'b1, 1'b0, 8'h01);
    vecs[2] = mk(32'h8000_0002, 1'b0, 38, 1'b1, 1'b0, 8'h02);
    vecs[3] = mk(32'h8000_0003, 1'b0, 18, 1'b1, 1'b0, 8'h03);
    vecs[4] = mk(32'h8000_0201, 1'b0, 18, 1'b1, 1'b1, 8'h01);
    vecs[5] = mk(32'h0000_020F, 1'b0, 18, 1'b0, 1'b1, 8'h0F);
    vecs[6] = mk(32'h8000_0038, 1'b0, 18, 1'b1, 1'b0, 8'h38);
    vecs[7] = mk(32'h7FFF_FD42, 1'b0, 18, 1'b0, 1'b0, 8'h42);
    vecs[8] = mk(32'h8000_0243, 1'b1, 18, 1'b1, 1'b1, 8'h43);

    rst       = 1'b1;
    lcd_wr_en = 1'b0;
    lcd_wdata = 32'h0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < N_VEC; i++) begin
      if (vecs[i].chain) repeat (prev_len - 1) @(negedge clk);
      else wait_idle();
      do_write(vecs[i]);
      prev_len = vecs[i].busy_len;
    end

    // A write during a transfer is dropped and flagged; the next accepted write clears the flag.
    wait_idle();
    do_write(mk(32'h8000_0038, 1'b0, 18, 1'b1, 1'b0, 8'h38));
    repeat (4) @(negedge clk);
    lcd_wr_en = 1'b1;
    lcd_wdata = 32'h8000_0255;
    @(negedge clk);
    lcd_wr_en = 1'b0;
    check("drop_set",   32'(lcd_drop), 32'h1);
    check("data_kept",  32'(lcd_data), 32'h38);
    check("rs_kept",    32'(lcd_rs),   32'h0);
    wait_idle();
    check("drop_sticky", 32'(lcd_drop), 32'h1);
    do_write(mk(32'h8000_0244, 1'b0, 18, 1'b1, 1'b1, 8'h44));
    check("data_after_drop", 32'(lcd_data), 32'h44);

    // Reset while the enable strobe is high abandons the transfer immediately.
    wait_idle();
    do_write(mk(32'h8000_0241, 1'b0, 18, 1'b1, 1'b1, 8'h41));
    wait_en();
    #2 rst = 1'b1;
    #1 check_all_zero("midrst");
    sb.delete();
    exp_busy.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    do_write(mk(32'h8000_0242, 1'b0, 18, 1'b1, 1'b1, 8'h42));

    wait_idle();
    repeat (3) @(negedge clk);
    check("strobes_drained", 32'(sb.size()), 32'h0);
    check("busy_drained",    32'(exp_busy.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
